// File: rtl/gray_conv_arbiter_if.sv
// Request/result bus for gray_conv_arbiter: requesters and consumer on the master
// side, the arbiter on the slave side.
interface gray_conv_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*W-1:0]       req_data;
  logic [N_REQ-1:0]         req_dir;
  logic [N_REQ-1:0]         gnt;
  logic                     out_valid;
  logic                     out_ready;
  logic [W-1:0]             out_data;
  logic [$clog2(N_REQ)-1:0] out_src;
  logic                     busy;

  modport master (
    output req, req_data, req_dir, out_ready,
    input  gnt, out_valid, out_data, out_src, busy
  );

  modport slave (
    input  req, req_data, req_dir, out_ready,
    output gnt, out_valid, out_data, out_src, busy
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary<->Gray converter among N_REQ requesters.
// Define GRAY_ARB_G2B_EN to enable per-request gray->bin selection via req_dir.
module gray_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4
) (
  input logic                clk,
  input logic                rst_n,
  gray_conv_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] cap_idx;
  logic [W-1:0]  cap_data;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          win_found;
  logic [W-1:0]  conv_res;

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

`ifdef GRAY_ARB_G2B_EN
  logic cap_dir;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b        = '0;
    b[W-1]   = g[W-1];
    for (int unsigned i = W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  always_comb begin
    conv_res = cap_dir ? gray2bin(cap_data) : bin2gray(cap_data);
  end
`else
  logic unused_dir;
  assign unused_dir = ^bus.req_dir;

  always_comb begin
    conv_res = bin2gray(cap_data);
  end
`endif

  // First set request at or above ptr, wrapping; N_REQ is a power of two so
  // IW-bit addition wraps for free.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ptr + IW'(i);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      cap_idx       <= '0;
      cap_data      <= '0;
`ifdef GRAY_ARB_G2B_EN
      cap_dir       <= 1'b0;
`endif
      bus.gnt       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.gnt <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            cap_idx          <= win_idx;
            cap_data         <= bus.req_data[int'(win_idx)*W +: W];
`ifdef GRAY_ARB_G2B_EN
            cap_dir          <= bus.req_dir[win_idx];
`endif
            bus.gnt[win_idx] <= 1'b1;
            bus.busy         <= 1'b1;
            state            <= CONV;
          end
        end
        CONV: begin
          bus.out_data  <= conv_res;
          bus.out_src   <= cap_idx;
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            ptr           <= cap_idx + IW'(1);
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Round-robin arbiter and sequencer that shares one 4-bit binary-to-Gray conversion datapath among several requesters. It captures one request at a time, converts it into a registered result, and holds that result under a valid/ready handshake until it is consumed. The block sits between multiple producers (counters, address generators) and a single downstream consumer of Gray-coded values.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; a power of two, 2 to 8.
- `W`, 4: data width in bits; minimum 2.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level; held until granted.
- `req_data`  in  N_REQ*W  requester k data on bits [k*W +: W].
- `req_dir`  in  N_REQ  per-requester direction (0 = bin→gray, 1 = gray→bin); used only under `GRAY_ARB_G2B_EN`.
- `gnt`  out  N_REQ  one-hot, one-cycle pulse: the request was captured.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  W  converted result.
- `out_src`  out  $clog2(N_REQ)  index of the requester that owns `out_data`.
- `busy`  out  1  high when state ≠ IDLE.

## Operation
- FSM states: IDLE, CONV, HOLD. Reset state is IDLE.
- IDLE:
  - If `req` ≠ 0 at a clock edge, pick winner k: the first set bit searching upward from `ptr`, wrapping modulo N_REQ.
  - Capture `req_data[k]` and `req_dir[k]`, set `gnt[k]` for the next cycle, and go to CONV.
  - If `req` = 0, stay in IDLE.
- CONV:
  - Load `out_data` with the converted value. Bin→gray: g = b ^ (b >> 1).
  - Set `out_src` = k and `out_valid` = 1, then go to HOLD.
  - `req` is not sampled in CONV.
- HOLD:
  - On an edge with `out_valid` && `out_ready`: clear `out_valid`, set `ptr` = (k+1) mod N_REQ, and go to IDLE.
  - Otherwise `out_data`, `out_src` and `out_valid` hold stable.
  - `req` is not sampled in HOLD.
- Requester rules:
  - Keep `req` and data stable until `gnt` is seen.
  - Dropping `req` before grant withdraws the request, with no side effects.
  - Keeping `req` high after `gnt` makes a new request; it is arbitrated in the next IDLE.
- `ptr` resets to 0. Granted requesters rotate, so no requester starves.
- Reset asserted at any time: all state clears immediately and any captured or pending result is discarded.
- Reset values: `gnt` = 0, `out_valid` = 0, `out_data` = 0, `out_src` = 0, `busy` = 0, `ptr` = 0.

## Timing
- Edge T (IDLE, `req` ≠ 0): `gnt[k]` is high and `busy` = 1 during cycle T+1.
- Edge T+1: `out_valid` = 1 and `out_data` valid from cycle T+2.
- The earliest next grant is at the edge after the handshake edge. Peak throughput is one result every 3 cycles.
- All outputs are registered, with no combinational path from input to output.
- `out_ready` high while `out_valid` is low has no effect.

## Configuration
- `GRAY_ARB_G2B_EN` defined:
  - The captured `req_dir` selects the conversion.
  - With `req_dir` = 1, gray→bin: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
- Macro undefined:
  - `req_dir` is ignored and is not registered.
  - Every conversion is bin→gray.

## Test plan
- Reset, then single requests with `req` = 0001 (W = 4), data in turn 0000, 0001, 0010, 0100, 1000, 1111:
  - Expected `out_data` 0000, 0001, 0011, 0110, 1100, 1000.
  - `out_src` = 0 for each; `gnt[0]` is a 1-cycle pulse; `out_valid` rises 2 cycles after the sampling edge.
- All four `req` held high, `out_ready` = 1:
  - Grant order 0, 1, 2, 3, 0.
  - Successive grants are exactly 3 cycles apart.
- Backpressure: hold `out_ready` low for 5 cycles while in HOLD with data 0100.
  - `out_data` stays 0110 and `out_valid` stays 1 throughout.
  - No `gnt` pulses during the stall; the next grant follows the handshake.
- Reset mid-HOLD with `out_valid` = 1:
  - Immediately `out_valid` = 0, `out_data` = 0, `busy` = 0.
  - After release, `req` = 1000 is granted first (`ptr` = 0), and `out_src` = 3.
- Direction select, `req_dir[1]` = 1, data 1000:
  - With `GRAY_ARB_G2B_EN` defined: `out_data` = 1111.
  - With the macro undefined: `out_data` = 1100.
